mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Pipeline MEM stage. Consumes the EX_MEM register outputs of the execute stage, runs a handshaked data-memory access for loads and stores, and loads the MEM_WB pipeline register.
- Drives the MEM- and WB-side forwarding sources that the execute stage's forwarding unit uses.
- Asserts a stall while a memory transaction is outstanding.

Parameters:
- TIMEOUT, 16: maximum REQ-state cycles without mem_ack before the access is aborted.
- CNT_W, 5: width of the timeout counter. Must hold TIMEOUT.

Ports:
- CLK  in  1  clock. All flops are rising-edge.
- RST  in  1  asynchronous, active-low reset.
- MemRead  in  1  load, from EX_MEM.
- MemWrite  in  1  store, from EX_MEM.
- RegWrite  in  1  writeback enable, from EX_MEM.
- MemtoReg  in  1  writeback source select (1 = memory data), from EX_MEM.
- alu_in  in  32  ALU result / effective address.
- readdata2_in  in  32  store data.
- rd_in  in  5  destination register.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  write strobe, registered.
- mem_addr  out  32  registered address.
- mem_wdata  out  32  registered store data.
- mem_rdata  in  32  load data, valid together with mem_ack.
- mem_ack  in  1  access complete.
- stall  out  1  freeze PC, IF/ID, ID/EX and EX_MEM.
- bus_err  out  1  sticky timeout flag.
- RegWrite_out  out  1  MEM_WB field.
- MemtoReg_out  out  1  MEM_WB field.
- alu_out  out  32  MEM_WB field.
- mem_data_out  out  32  MEM_WB field.
- rd_out  out  5  MEM_WB field.
- MEMRegRd  out  5  equals rd_in (combinational).
- MEM_RegWrite  out  1  equals RegWrite (combinational).
- regExMem  out  32  equals alu_in (combinational).
- regMemWb  out  32  MemtoReg_out ? mem_data_out : alu_out.

Behaviour:
- Reset (RST low, asynchronous): state = IDLE; every registered output = 0; bus_err = 0; counter = 0. mem_req drops immediately, including in the middle of a transaction.
- memop = MemRead | MemWrite. If both are high, the access is a write and the read is ignored.
- FSM states: IDLE, REQ, DONE.
- IDLE with memop = 0:
  - stall = 0.
  - MEM_WB captures RegWrite, MemtoReg, alu_in, rd_in.
  - mem_data_out <= 0.
  - Latency is 1 cycle.
- IDLE with memop = 1:
  - stall = 1.
  - On the next edge: go to REQ; mem_req <= 1; mem_we <= MemWrite; mem_addr <= alu_in; mem_wdata <= readdata2_in; counter <= 0.
- REQ:
  - stall = 1.
  - mem_ack = 1 at an edge: rdata_q <= mem_rdata (reads only); mem_req <= 0; mem_we <= 0; go to DONE.
  - Otherwise the counter increments. When counter == TIMEOUT-1 without ack: mem_req <= 0; bus_err <= 1; rdata_q <= 0; go to DONE.
  - mem_addr, mem_wdata and mem_we are held stable while mem_req = 1.
- DONE:
  - stall = 0.
  - On the edge: MEM_WB captures the control fields, alu_in, rd_in, and mem_data_out <= rdata_q; state returns to IDLE.
  - Upstream advances on the same edge.
- While stall = 1, every edge writes RegWrite_out <= 0 (bubble to WB). Other MEM_WB fields hold.
- Minimum load/store latency is 3 cycles (ack on the first REQ cycle). Each extra cycle of ack delay adds 1 cycle.
- mem_ack while in IDLE or DONE is ignored.
- bus_err clears only on reset.
- No byte or halfword accesses; word only.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - In IDLE with memop = 1 and alu_in[1:0] != 0, no request is issued. The FSM goes straight to DONE on the next edge; stall = 1 for that IDLE cycle only.
  - The result is written back with RegWrite_out = 0.
  - Output misalign (1 bit, registered) pulses high for the DONE cycle.
- Undefined:
  - No misalign port.
  - Address bits [1:0] are passed to mem_addr unchanged and accesses are issued normally.

Test Plan:
- Reset: hold RST = 0 with random inputs -> every output 0 and stall = 0. Assert RST mid-REQ -> mem_req = 0 immediately and state returns to IDLE.
- R-type passthrough: RegWrite = 1, alu_in = 0x0000_002A, rd_in = 5, no memop -> next edge RegWrite_out = 1, alu_out = 0x2A, rd_out = 5, regMemWb = 0x2A, stall never high.
- Load with ack on the first REQ cycle: MemRead = 1, MemtoReg = 1, alu_in = 0x100, mem_rdata = 0xCAFEBABE -> mem_req high for 1 cycle, stall high for 2 cycles, then mem_data_out = 0xCAFEBABE, regMemWb = 0xCAFEBABE, RegWrite_out = 1.
- Store with ack delayed 4 cycles: MemWrite = 1, alu_in = 0x200, readdata2_in = 0x1234 -> mem_we = 1, mem_wdata = 0x1234, mem_addr = 0x200 stable for 5 cycles; RegWrite_out = 0 throughout; stall = 1 for 6 cycles.
- Timeout: load, ack never arrives -> mem_req drops after 16 REQ cycles, bus_err = 1 (sticky), mem_data_out = 0, pipeline resumes.
- MemRead = MemWrite = 1 -> mem_we = 1. With MEM_ALIGN_CHECK_EN, alu_in = 0x102 -> no mem_req, misalign pulses, RegWrite_out = 0.

Source files
------------

// File: rtl/mem_access_stage.sv
// ============================================================================
// mem_access_stage
// ----------------------------------------------------------------------------
// Purpose:
//    MEM stage of the pipeline. Takes the EX_MEM register fields from the
//    execute stage and runs a handshaked word access to data memory for loads
//    and stores. It then loads the MEM_WB pipeline register. It also drives
//    the MEM-side and WB-side forwarding sources, and freezes the upstream
//    pipeline with 'stall' while a memory transaction is outstanding.
//
// Optional build macro:
//    MEM_ALIGN_CHECK_EN - when defined, a memory op whose address has
//    alu_in[1:0] != 0 is not issued to memory. It completes through DONE with
//    RegWrite_out = 0, and the registered 'misalign' output pulses for the
//    DONE cycle. When undefined, there is no 'misalign' port, and every
//    access is issued with the address passed through unchanged.
//
// Ports:
//    CLK, RST                   rising-edge clock, asynchronous active-low reset
//    MemRead, MemWrite          load / store request from EX_MEM
//    RegWrite, MemtoReg         writeback controls from EX_MEM
//    alu_in, readdata2_in       effective address / ALU result, store data
//    rd_in                      destination register
//    mem_req, mem_we            registered memory request and write strobe
//    mem_addr, mem_wdata        registered address and store data
//    mem_rdata, mem_ack         load data and access-complete handshake
//    stall                      freezes PC, IF/ID, ID/EX and EX_MEM
//    bus_err                    sticky access-timeout flag
//    RegWrite_out .. rd_out     MEM_WB register fields
//    MEMRegRd, MEM_RegWrite,
//    regExMem                   MEM-side forwarding sources (combinational)
//    regMemWb                   WB-side forwarding source
//    misalign                   (MEM_ALIGN_CHECK_EN only) misaligned-access pulse
// ============================================================================
module mem_access_stage #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic        RegWrite,
   input  logic        MemtoReg,
   input  logic [31:0] alu_in,
   input  logic [31:0] readdata2_in,
   input  logic [4:0]  rd_in,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        stall,
   output logic        bus_err,
   output logic        RegWrite_out,
   output logic        MemtoReg_out,
   output logic [31:0] alu_out,
   output logic [31:0] mem_data_out,
   output logic [4:0]  rd_out,
   output logic [4:0]  MEMRegRd,
   output logic        MEM_RegWrite,
   output logic [31:0] regExMem,
   output logic [31:0] regMemWb
`ifdef MEM_ALIGN_CHECK_EN
   ,
   output logic        misalign
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_q,      state_d;
   logic        mem_req_q,    mem_req_d;
   logic        mem_we_q,     mem_we_d;
   logic [31:0] mem_addr_q,   mem_addr_d;
   logic [31:0] mem_wdata_q,  mem_wdata_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic        bus_err_q,    bus_err_d;
   logic [31:0] rdata_q,      rdata_d;
   logic        misalign_q,   misalign_d;
   logic        rw_q,         rw_d;
   logic        m2r_q,        m2r_d;
   logic [31:0] alu_q,        alu_d;
   logic [31:0] md_q,         md_d;
   logic [4:0]  rd_q,         rd_d;

   logic        memop;
   logic        misaligned;
   logic        stall_c;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   // A simultaneous read and write is treated as a write. mem_we follows MemWrite.
   assign memop = MemRead | MemWrite;

`ifdef MEM_ALIGN_CHECK_EN
   assign misaligned = (alu_in[1:0] != 2'b00);
`else
   assign misaligned = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      cnt_d       = cnt_q;
      bus_err_d   = bus_err_q;
      rdata_d     = rdata_q;
      misalign_d  = misalign_q;
      rw_d        = rw_q;
      m2r_d       = m2r_q;
      alu_d       = alu_q;
      md_d        = md_q;
      rd_d        = rd_q;
      stall_c     = 1'b0;

      case (state_q)
         IDLE: begin
            if (memop) begin
               // Hold EX_MEM and send a bubble to WB while the access runs.
               stall_c = 1'b1;
               rw_d    = 1'b0;
               if (misaligned) begin
                  state_d    = DONE;
                  rdata_d    = 32'd0;
                  misalign_d = 1'b1;
               end else begin
                  state_d     = REQ;
                  mem_req_d   = 1'b1;
                  mem_we_d    = MemWrite;
                  mem_addr_d  = alu_in;
                  mem_wdata_d = readdata2_in;
                  cnt_d       = '0;
               end
            end else begin
               rw_d  = RegWrite;
               m2r_d = MemtoReg;
               alu_d = alu_in;
               rd_d  = rd_in;
               md_d  = 32'd0;
            end
         end

         REQ: begin
            stall_c = 1'b1;
            rw_d    = 1'b0;
            if (mem_ack) begin
               if (!mem_we_q) begin
                  rdata_d = mem_rdata;
               end
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               state_d   = DONE;
            end else if (cnt_q == CNT_LAST) begin
               // Abort: the load result reads as zero and the error stays set.
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               bus_err_d = 1'b1;
               rdata_d   = 32'd0;
               state_d   = DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         DONE: begin
            // EX_MEM still holds the memory instruction; upstream advances on this edge.
            rw_d       = RegWrite & ~misalign_q;
            m2r_d      = MemtoReg;
            alu_d      = alu_in;
            rd_d       = rd_in;
            md_d       = rdata_q;
            misalign_d = 1'b0;
            state_d    = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q     <= IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'd0;
         mem_wdata_q <= 32'd0;
         cnt_q       <= '0;
         bus_err_q   <= 1'b0;
         rdata_q     <= 32'd0;
         misalign_q  <= 1'b0;
         rw_q        <= 1'b0;
         m2r_q       <= 1'b0;
         alu_q       <= 32'd0;
         md_q        <= 32'd0;
         rd_q        <= 5'd0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         cnt_q       <= cnt_d;
         bus_err_q   <= bus_err_d;
         rdata_q     <= rdata_d;
         misalign_q  <= misalign_d;
         rw_q        <= rw_d;
         m2r_q       <= m2r_d;
         alu_q       <= alu_d;
         md_q        <= md_d;
         rd_q        <= rd_d;
      end
   end

   // Stall is forced low during reset so that the upstream stages are not frozen.
   assign stall        = stall_c & RST;

   assign mem_req      = mem_req_q;
   assign mem_we       = mem_we_q;
   assign mem_addr     = mem_addr_q;
   assign mem_wdata    = mem_wdata_q;
   assign bus_err      = bus_err_q;

   assign RegWrite_out = rw_q;
   assign MemtoReg_out = m2r_q;
   assign alu_out      = alu_q;
   assign mem_data_out = md_q;
   assign rd_out       = rd_q;

   assign MEMRegRd     = rd_in;
   assign MEM_RegWrite = RegWrite;
   assign regExMem     = alu_in;
   assign regMemWb     = m2r_q ? md_q : alu_q;

`ifdef MEM_ALIGN_CHECK_EN
   assign misalign     = misalign_q;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: directed transactions, with an expected
// MEM_WB queue that is consumed by an independent monitor process.
module tb_mem_access_stage;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        MemRead = 1'b0, MemWrite = 1'b0, RegWrite = 1'b0, MemtoReg = 1'b0;
   logic [31:0] alu_in = 32'd0, readdata2_in = 32'd0;
   logic [4:0]  rd_in = 5'd0;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [31:0] mem_rdata = 32'd0;
   logic        mem_ack = 1'b0;
   logic        stall, bus_err;
   logic        RegWrite_out, MemtoReg_out;
   logic [31:0] alu_out, mem_data_out;
   logic [4:0]  rd_out, MEMRegRd;
   logic        MEM_RegWrite;
   logic [31:0] regExMem, regMemWb;
`ifdef MEM_ALIGN_CHECK_EN
   logic        misalign;
`endif

   mem_access_stage #(.TIMEOUT(16), .CNT_W(5)) dut (
      .CLK(CLK), .RST(RST),
      .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
      .alu_in(alu_in), .readdata2_in(readdata2_in), .rd_in(rd_in),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .stall(stall), .bus_err(bus_err),
      .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out),
      .alu_out(alu_out), .mem_data_out(mem_data_out), .rd_out(rd_out),
      .MEMRegRd(MEMRegRd), .MEM_RegWrite(MEM_RegWrite),
      .regExMem(regExMem), .regMemWb(regMemWb)
`ifdef MEM_ALIGN_CHECK_EN
      , .misalign(misalign)
`endif
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic        rw;
      logic        m2r;
      logic [31:0] alu;
      logic [31:0] md;
      logic [4:0]  rd;
      logic        chk_md;
   } exp_t;

   exp_t sbq[$];
   int   tests = 0;
   int   fails = 0;

   // Memory responder: acks on REQ cycle number ack_delay (0 = first), never if < 0.
   int          ack_delay = -1;
   int          req_cnt   = 0;
   logic [31:0] rdata_v   = 32'd0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   always @(negedge CLK) begin
      mem_rdata = rdata_v;
      if (mem_req) begin
         mem_ack = (ack_delay >= 0) && (req_cnt == ack_delay);
         req_cnt++;
      end else begin
         mem_ack = 1'b0;
         req_cnt = 0;
      end
   end

   // Monitor: a negedge with stall low means the next edge loads MEM_WB;
   // the following negedge compares it against the oldest expectation.
   initial begin
      bit armed;
      exp_t e;
      armed = 1'b0;
      forever begin
         @(negedge CLK);
         if (armed) begin
            if (sbq.size() == 0) begin
               chk("mon_underflow", 32'd1, 32'd0);
            end else begin
               e = sbq.pop_front();
               chk("wb_RegWrite", 32'(RegWrite_out), 32'(e.rw));
               chk("wb_MemtoReg", 32'(MemtoReg_out), 32'(e.m2r));
               chk("wb_alu", alu_out, e.alu);
               chk("wb_rd", 32'(rd_out), 32'(e.rd));
               if (e.chk_md) begin
                  chk("wb_mem_data", mem_data_out, e.md);
                  chk("wb_regMemWb", regMemWb, e.m2r ? e.md : e.alu);
               end else if (!e.m2r) begin
                  chk("wb_regMemWb", regMemWb, e.alu);
               end
               $display("[TB] WB rd=%0d rw=%0b alu=0x%08h md=0x%08h", rd_out, RegWrite_out,
                        alu_out, mem_data_out);
            end
         end
         armed = RST && !stall && (sbq.size() > 0);
      end
   end

   // Issue one EX_MEM instruction (called just after a capture edge) and
   // follow it until MEM_WB is loaded.
   task automatic issue(input logic mr, input logic mw, input logic rw, input logic m2r,
                        input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                        input logic [31:0] rdata, input int delay,
                        input int exp_stall, input int exp_req, input logic exp_we,
                        input logic exp_rw, input logic [31:0] exp_md, input logic chk_md,
                        input string tag);
      int  nst, nreq;
      bit  prev, done;
      exp_t e;
      MemRead = mr; MemWrite = mw; RegWrite = rw; MemtoReg = m2r;
      alu_in = alu; readdata2_in = wd; rd_in = rd;
      ack_delay = delay; rdata_v = rdata;
      e.rw = exp_rw; e.m2r = m2r; e.alu = alu; e.md = exp_md; e.rd = rd; e.chk_md = chk_md;
      sbq.push_back(e);
      nst = 0; nreq = 0; prev = 1'b0; done = 1'b0;
      for (int c = 0; c < 64 && !done; c++) begin
         @(negedge CLK);
         if (prev) chk({tag, "_bubble"}, 32'(RegWrite_out), 32'd0);
         if (mem_req) begin
            nreq++;
            chk({tag, "_addr"}, mem_addr, alu);
            chk({tag, "_wdata"}, mem_wdata, wd);
            chk({tag, "_we"}, 32'(mem_we), 32'(exp_we));
         end
         prev = stall;
         if (stall) nst++;
         @(posedge CLK);
         #1;
         if (!prev) done = 1'b1;
      end
      if (!done) chk({tag, "_cycle_budget"}, 32'd0, 32'd1);
      chk({tag, "_stall_cycles"}, 32'(nst), 32'(exp_stall));
      chk({tag, "_req_cycles"}, 32'(nreq), 32'(exp_req));
      $display("[TB] %s: stall=%0d req=%0d", tag, nst, nreq);
   endtask

   initial begin
      // Reset held low with random EX_MEM and memory inputs.
      for (int i = 0; i < 2; i++) begin
         MemRead = 1'($urandom); MemWrite = 1'($urandom); RegWrite = 1'($urandom);
         MemtoReg = 1'($urandom); alu_in = $urandom; readdata2_in = $urandom;
         rd_in = 5'($urandom); rdata_v = $urandom;
         #3;
         chk("rst_mem_req", 32'(mem_req), 32'd0);
         chk("rst_mem_we", 32'(mem_we), 32'd0);
         chk("rst_mem_addr", mem_addr, 32'd0);
         chk("rst_mem_wdata", mem_wdata, 32'd0);
         chk("rst_stall", 32'(stall), 32'd0);
         chk("rst_bus_err", 32'(bus_err), 32'd0);
         chk("rst_RegWrite_out", 32'(RegWrite_out), 32'd0);
         chk("rst_MemtoReg_out", 32'(MemtoReg_out), 32'd0);
         chk("rst_alu_out", alu_out, 32'd0);
         chk("rst_mem_data_out", mem_data_out, 32'd0);
         chk("rst_rd_out", 32'(rd_out), 32'd0);
         chk("rst_regMemWb", regMemWb, 32'd0);
         $display("[TB] reset check %0d", i);
         @(posedge CLK);
         #1;
      end
      MemRead = 0; MemWrite = 0; RegWrite = 0; MemtoReg = 0;
      alu_in = 0; readdata2_in = 0; rd_in = 0; rdata_v = 0;
      @(negedge CLK);
      RST = 1'b1;
      @(posedge CLK);
      #1;

      // R-type passthrough, then forwarding sources check against live inputs.
      issue(0, 0, 1, 0, 32'h0000_002A, 32'h0, 5'd5, 32'h0, -1, 0, 0, 0, 1, 32'h0, 1, "rtype");
      RegWrite = 1; rd_in = 5'd12; alu_in = 32'h0BAD_F00D;
      #1;
      chk("fwd_MEMRegRd", 32'(MEMRegRd), 32'd12);
      chk("fwd_MEM_RegWrite", 32'(MEM_RegWrite), 32'd1);
      chk("fwd_regExMem", regExMem, 32'h0BAD_F00D);

      // Load, ack on the first REQ cycle.
      issue(1, 0, 1, 1, 32'h0000_0100, 32'h0, 5'd7, 32'hCAFE_BABE, 0,
            2, 1, 0, 1, 32'hCAFE_BABE, 1, "load_ack0");
      // Store, ack delayed by 4 cycles.
      issue(0, 1, 0, 0, 32'h0000_0200, 32'h0000_1234, 5'd0, 32'hFFFF_FFFF, 4,
            6, 5, 1, 0, 32'h0, 0, "store_ack4");
      // Read and write together: treated as a write.
      issue(1, 1, 0, 0, 32'h0000_0300, 32'h0000_55AA, 5'd0, 32'h1111_1111, 1,
            3, 2, 1, 0, 32'h0, 0, "rw_both");
      issue(0, 0, 1, 0, 32'hDEAD_BEEF, 32'h0, 5'd31, 32'h0, -1, 0, 0, 0, 1, 32'h0, 1, "rtype2");

      // Reset asserted in the middle of REQ.
      MemRead = 1; MemWrite = 0; RegWrite = 1; MemtoReg = 1; alu_in = 32'h0000_0500;
      rd_in = 5'd8; ack_delay = -1;
      repeat (3) @(posedge CLK);
      #2;
      chk("midreq_req_before", 32'(mem_req), 32'd1);
      RST = 1'b0;
      #1;
      chk("midreq_req_after", 32'(mem_req), 32'd0);
      chk("midreq_stall", 32'(stall), 32'd0);
      chk("midreq_addr", mem_addr, 32'd0);
      $display("[TB] reset asserted mid-REQ");
      MemRead = 0; RegWrite = 0; MemtoReg = 0; alu_in = 0; rd_in = 0;
      @(negedge CLK);
      RST = 1'b1;
      @(posedge CLK);
      #1;
      issue(0, 0, 1, 0, 32'h0000_0001, 32'h0, 5'd3, 32'h0, -1, 0, 0, 0, 1, 32'h0, 1, "after_rst");

`ifdef MEM_ALIGN_CHECK_EN
      issue(1, 0, 1, 1, 32'h0000_0102, 32'h0, 5'd4, 32'h0, -1, 1, 0, 0, 0, 32'h0, 1, "misalign");
`endif

      // Timeout: ack never arrives.
      chk("bus_err_before", 32'(bus_err), 32'd0);
      issue(1, 0, 1, 1, 32'h0000_0400, 32'h0, 5'd9, 32'hABCD_0123, -1,
            17, 16, 0, 1, 32'h0, 1, "timeout");
      chk("bus_err_set", 32'(bus_err), 32'd1);
      issue(0, 0, 1, 0, 32'h0000_0077, 32'h0, 5'd10, 32'h0, -1, 0, 0, 0, 1, 32'h0, 1, "rtype3");
      chk("bus_err_sticky", 32'(bus_err), 32'd1);

      MemRead = 0; MemWrite = 0; RegWrite = 0; MemtoReg = 0;
      repeat (3) @(negedge CLK);
      chk("sb_drained", 32'(sbq.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "time limit");
   end

endmodule
